// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, default
// word/divider sizes and the mode-0 clock polarity/phase constants.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_TRAIL = 3'd4
  } spi_state_t;

  localparam int SPI_DATA_W  = 8;
  localparam int SPI_CLK_DIV = 4;

  // Mode 0: SCLK idles low, data is sampled on the rising half.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter for the SPI master: counts 0..CLK_DIV-1 and pulses
// o_tc on the terminal count; i_restart holds it at zero.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_restart,
  output logic o_tc
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tc = (r_cnt == LAST_CNT);

  always_ff @(posedge i_clk) begin
    if (i_clr || i_restart || o_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one-word transfers with CS_N/SCLK/MOSI generation and
// MISO capture. Define SPI_LSB_FIRST_EN for LSB-first bit order.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              START,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              MISO,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              SCLK,
  output logic              MOSI,
  output logic              CS_N,
  output spi_state_t        DBG_STATE
);

  // Handshake: START is accepted only in IDLE (BUSY=0); BUSY stays high from
  // the accept edge until the edge that raises DONE for exactly one cycle.
  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  spi_state_t        r_state, w_next;
  logic              w_tc, w_accept, w_sample, w_last, w_finish;
  logic              w_first_bit, w_next_bit;
  logic [DATA_W-1:0] w_tx_shift, w_rx_shift;
  logic [DATA_W-1:0] r_tx, r_rx, r_rx_data;
  logic [BW-1:0]     r_bit;
  logic              r_mosi, r_done;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .i_clk     (CLK),
    .i_clr     (CLR),
    .i_restart (r_state == ST_IDLE),
    .o_tc      (w_tc)
  );

  always_ff @(posedge CLK) begin
    if (CLR) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (START) w_next = ST_LEAD;
      ST_LEAD:  if (w_tc)  w_next = ST_HIGH;
      ST_HIGH:  if (w_tc)  w_next = w_last ? ST_TRAIL : ST_LOW;
      ST_LOW:   if (w_tc)  w_next = ST_HIGH;
      ST_TRAIL: if (w_tc)  w_next = ST_IDLE;
      default:             w_next = ST_IDLE;
    endcase
  end

  assign w_accept = (r_state == ST_IDLE) && START;
  assign w_sample = (r_state == ST_HIGH) && w_tc;
  assign w_finish = (r_state == ST_TRAIL) && w_tc;
  assign w_last   = (r_bit == LAST_BIT);

`ifdef SPI_LSB_FIRST_EN
  assign w_first_bit = TX_DATA[0];
  assign w_next_bit  = r_tx[1];
  assign w_tx_shift  = r_tx >> 1;
  assign w_rx_shift  = {MISO, r_rx[DATA_W-1:1]};
`else
  assign w_first_bit = TX_DATA[DATA_W-1];
  assign w_next_bit  = r_tx[DATA_W-2];
  assign w_tx_shift  = r_tx << 1;
  assign w_rx_shift  = {r_rx[DATA_W-2:0], MISO};
`endif

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_bit     <= '0;
      r_mosi    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_tx   <= TX_DATA;
        r_mosi <= w_first_bit;
        r_bit  <= '0;
      end
      // The HIGH exit edge is the SCLK falling edge: sample MISO, launch next bit.
      if (w_sample) begin
        r_rx <= w_rx_shift;
        if (!w_last) begin
          r_bit  <= r_bit + 1'b1;
          r_tx   <= w_tx_shift;
          r_mosi <= w_next_bit;
        end
      end
      if (w_finish) r_rx_data <= r_rx;
    end
  end

  assign SCLK      = (r_state == ST_HIGH) ? ~SPI_CPOL : SPI_CPOL;
  assign CS_N      = (r_state == ST_IDLE);
  assign BUSY      = (r_state != ST_IDLE);
  assign MOSI      = r_mosi;
  assign DONE      = r_done;
  assign RX_DATA   = r_rx_data;
  assign DBG_STATE = r_state;

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

SPI master controller (mode 0: CPOL=0, CPHA=0) that sequences the SPI shift datapath in the SPI interface. It accepts a one-word transfer request over a START/BUSY/DONE handshake and drives CS_N, SCLK and MOSI. It samples MISO into a receive shift register and returns the received word with a one-cycle DONE pulse.

## Interface
- DATA_W, 8: bits per transfer, ≥ 2.
- CLK_DIV, 4: CLK cycles per SCLK half-period, ≥ 1.

- CLK  input  1  system clock; all logic on posedge.
- CLR  input  1  reset, synchronous, active-high; priority over every other input.
- START  input  1  transfer request; sampled only in IDLE.
- TX_DATA  input  DATA_W  word to transmit; captured on the START-accept edge.
- MISO  input  1  serial data from slave.
- RX_DATA  output  DATA_W  last received word; updated only with DONE.
- BUSY  output  1  high from the accept edge until the DONE edge.
- DONE  output  1  one-cycle pulse at transfer end.
- SCLK  output  1  serial clock, idle low.
- MOSI  output  1  serial data to slave.
- CS_N  output  1  slave select, active-low.

## Operation
- Reset values, applied on any edge with CLR=1: state IDLE, SCLK=0, CS_N=1, MOSI=0, BUSY=0, DONE=0, RX_DATA=0, shift registers 0, divider counter 0.
- FSM states:
  - IDLE: waits for START.
  - LEAD: CS_N=0, SCLK=0, first bit on MOSI.
  - HIGH: SCLK=1.
  - LOW: SCLK=0.
  - TRAIL: CS_N=0, SCLK=0.
- Every state except IDLE lasts exactly CLK_DIV cycles. The divider counter counts 0..CLK_DIV-1, and its terminal count advances the FSM.
- IDLE → LEAD when START=1:
  - load TX shift register with TX_DATA;
  - drive MOSI with the first bit;
  - CS_N=0, BUSY=1, bit counter=0.
- LEAD → HIGH.
- HIGH exit edge: shift MISO into the RX shift register.
  - If bit counter = DATA_W-1 → TRAIL.
  - Otherwise → LOW, increment the bit counter, and drive MOSI with the next bit on this same edge (the SCLK falling edge).
- LOW → HIGH.
- TRAIL → IDLE: CS_N=1, BUSY=0, DONE=1 for one cycle, RX_DATA ← RX shift register. MOSI holds its last value.
- Bit order: MSB first, for both TX and RX.
- START while BUSY=1: ignored, not queued.
- TX_DATA changes after the accept edge: no effect on the current transfer.
- START=1 in the cycle where DONE=1: the FSM is in IDLE, so the request is accepted. CS_N is then high for exactly one cycle between the two transfers.
- CLR mid-transfer: abort on that edge. All outputs take reset values, no DONE is produced, and RX_DATA is cleared.

## Timing
- Accept edge = edge 0.
- Outputs after edge 0: CS_N=0, BUSY=1, MOSI = bit 0.
- SCLK rises CLK_DIV edges later, at edge CLK_DIV.
- SCLK period is 2·CLK_DIV CLK cycles. There are exactly DATA_W SCLK rising edges per transfer.
- MISO is sampled on the last CLK cycle of each HIGH half, i.e. the edge on which SCLK falls.
- DONE rises at edge CLK_DIV·(2·DATA_W+1). With the defaults this is edge 68, with DONE high for cycle 69 only.
- Minimum CS_N-high gap between back-to-back transfers: 1 cycle.

## Configuration
- SPI_LSB_FIRST_EN defined: bit 0 is transmitted first, and the first received bit lands in RX_DATA[0].
- SPI_LSB_FIRST_EN undefined: MSB first on both TX and RX.
- Timing is identical either way.

## Structure
- Shared package spi_pkg holds:
  - the FSM state encoding (IDLE, LEAD, HIGH, LOW, TRAIL);
  - default DATA_W and CLK_DIV constants;
  - the mode-0 CPOL/CPHA constants.
- Sub-module spi_clk_div: half-period counter with a synchronous restart input and a terminal-count pulse output.
- The FSM, bit counter and both shift registers stay in spi_master_ctrl.

## Test plan
- Reset: CLR=1 for 2 cycles with START=1 → SCLK=0, CS_N=1, MOSI=0, BUSY=0, DONE=0, RX_DATA=0; no transfer starts.
- Loopback (MISO=MOSI), TX_DATA=8'hA5, defaults:
  - MOSI at successive SCLK rises = 1,0,1,0,0,1,0,1;
  - 8 SCLK rises;
  - DONE at edge 68;
  - RX_DATA=8'hA5.
- Slave model shifting out 8'h3C on SCLK falls, TX_DATA=8'hFF → RX_DATA=8'h3C; MOSI constant 1 while CS_N=0.
- START held high for 200 cycles: first transfer accepted at edge 0. A second transfer is accepted in the first DONE cycle. CS_N is high 1 cycle between transfers, and BUSY is never high for more than one transfer without an intervening DONE.
- CLR at edge 20 of a transfer → next outputs CS_N=1, SCLK=0, BUSY=0, RX_DATA=0, no DONE. A subsequent START with 8'h5A completes normally, returning RX_DATA=8'h5A in loopback.
- With SPI_LSB_FIRST_EN, loopback, TX_DATA=8'h01 → first MOSI bit 1, remaining 7 bits 0; RX_DATA=8'h01; DONE at edge 68.
